// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter/sequencer:
// ALU op codes, FSM state encodings and default widths.
package alu_share_arb_pkg;

   localparam int unsigned AluW   = 32;
   localparam int unsigned AluOpW = 3;

   // Op codes are forwarded untouched to the external ALU; listed for users.
   localparam logic [2:0] OpAnd = 3'b000;
   localparam logic [2:0] OpOr  = 3'b001;
   localparam logic [2:0] OpAdd = 3'b010;
   localparam logic [2:0] OpXor = 3'b011;
   localparam logic [2:0] OpSub = 3'b110;
   localparam logic [2:0] OpSlt = 3'b111;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StExec = 2'b01,
      StResp = 2'b10
   } state_e;

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// Combinational two-way round-robin picker: a lone valid requester wins,
// a tie goes to the requester that was not granted last.
module rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_gnt,
   output logic gnt0,
   output logic gnt1
);

   always_comb begin
      gnt0 = valid0 & (~valid1 | last_gnt);
      gnt1 = valid1 & (~valid0 | ~last_gnt);
   end

endmodule

// File: rtl/alu_share_arb.sv
// Arbiter and sequencer in front of a shared combinational ALU.
// Optional grant counters are enabled with ALU_ARB_STATS_EN.
module alu_share_arb
   import alu_share_arb_pkg::*;
#(
   parameter int unsigned W   = AluW,
   parameter int unsigned OPW = AluOpW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [OPW-1:0] req0_op,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [OPW-1:0] req1_op,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   output logic [OPW-1:0] alu_op,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   input  logic [W-1:0]   alu_r,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic           resp_id,
   output logic [W-1:0]   resp_r
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]    gnt_cnt0,
   output logic [15:0]    gnt_cnt1
`endif
);

   state_e         state_q, state_d;
   logic [OPW-1:0] alu_op_q, alu_op_d;
   logic [W-1:0]   alu_a_q, alu_a_d;
   logic [W-1:0]   alu_b_q, alu_b_d;
   logic           resp_valid_q, resp_valid_d;
   logic           resp_id_q, resp_id_d;
   logic [W-1:0]   resp_r_q, resp_r_d;
   logic           last_gnt_q, last_gnt_d;

   logic gnt0, gnt1;
   logic hs0, hs1;

   rr_arb2 u_rr_arb2 (
      .valid0   (req0_valid),
      .valid1   (req1_valid),
      .last_gnt (last_gnt_q),
      .gnt0     (gnt0),
      .gnt1     (gnt1)
   );

   always_comb begin
      req0_ready = (state_q == StIdle) & gnt0;
      req1_ready = (state_q == StIdle) & gnt1;
      hs0        = req0_valid & req0_ready;
      hs1        = req1_valid & req1_ready;
   end

   always_comb begin
      state_d      = state_q;
      alu_op_d     = alu_op_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_r_d     = resp_r_q;
      last_gnt_d   = last_gnt_q;
      unique case (state_q)
         StIdle: begin
            if (hs0) begin
               alu_op_d   = req0_op;
               alu_a_d    = req0_a;
               alu_b_d    = req0_b;
               resp_id_d  = 1'b0;
               last_gnt_d = 1'b0;
               state_d    = StExec;
            end else if (hs1) begin
               alu_op_d   = req1_op;
               alu_a_d    = req1_a;
               alu_b_d    = req1_b;
               resp_id_d  = 1'b1;
               last_gnt_d = 1'b1;
               state_d    = StExec;
            end
         end
         // One cycle for the external ALU to settle on the registered operands.
         StExec: begin
            resp_r_d     = alu_r;
            resp_valid_d = 1'b1;
            state_d      = StResp;
         end
         StResp: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = StIdle;
            end
         end
         default: begin
            resp_valid_d = 1'b0;
            state_d      = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         alu_op_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_r_q     <= '0;
         last_gnt_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         alu_op_q     <= alu_op_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_r_q     <= resp_r_d;
         last_gnt_q   <= last_gnt_d;
      end
   end

   always_comb begin
      alu_op     = alu_op_q;
      alu_a      = alu_a_q;
      alu_b      = alu_b_q;
      resp_valid = resp_valid_q;
      resp_id    = resp_id_q;
      resp_r     = resp_r_q;
   end

`ifdef ALU_ARB_STATS_EN
   logic [15:0] cnt0_q, cnt0_d;
   logic [15:0] cnt1_q, cnt1_d;

   // Saturating handshake counters.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (hs0 && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
      if (hs1 && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   always_comb begin
      gnt_cnt0 = cnt0_q;
      gnt_cnt1 = cnt1_q;
   end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb with a small ALU model
// driving alu_r from the registered operands.
module tb_alu_share_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready;
   logic [2:0]  req0_op;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [2:0]  req1_op;
   logic [31:0] req1_a, req1_b;
   logic [2:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_r;
   logic        resp_valid, resp_ready, resp_id;
   logic [31:0] resp_r;
`ifdef ALU_ARB_STATS_EN
   logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   alu_share_arb dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_r      (alu_r),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_r     (resp_r)
`ifdef ALU_ARB_STATS_EN
      ,
      .gnt_cnt0   (gnt_cnt0),
      .gnt_cnt1   (gnt_cnt1)
`endif
   );

   always_comb begin
      case (alu_op)
         3'b000:  alu_r = alu_a & alu_b;
         3'b001:  alu_r = alu_a | alu_b;
         3'b010:  alu_r = alu_a + alu_b;
         3'b011:  alu_r = alu_a ^ alu_b;
         3'b110:  alu_r = alu_a - alu_b;
         3'b111:  alu_r = {31'd0, $signed(alu_a) < $signed(alu_b)};
         default: alu_r = 32'd0;
      endcase
   end

   task automatic do_reset();
      rst        = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
      resp_ready = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({resp_valid, resp_id, resp_r, alu_op, alu_a, alu_b} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got v=%0b id=%0b r=%h op=%0d a=%h b=%h required all 0",
                  resp_valid, resp_id, resp_r, alu_op, alu_a, alu_b);
      end
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_readys: got %b required 00", {req0_ready, req1_ready});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_or();
      do_reset();
      req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'hFFFF0000; req0_b = 32'h0000FFFF;
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++;
         $display("FAIL or_ready: got %b required 10", {req0_ready, req1_ready});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      tests_run++;
      if ({resp_valid, alu_op, alu_a, alu_b} !== {1'b0, 3'b001, 32'hFFFF0000, 32'h0000FFFF}) begin
         tests_failed++;
         $display("FAIL or_exec: got v=%0b op=%0d a=%h b=%h required v=0 op=1 a=ffff0000 b=0000ffff",
                  resp_valid, alu_op, alu_a, alu_b);
      end
      @(negedge clk);
      tests_run++;
      if ({resp_valid, resp_id, resp_r} !== {1'b1, 1'b0, 32'hFFFFFFFF}) begin
         tests_failed++;
         $display("FAIL or_resp: got v=%0b id=%0b r=%h required v=1 id=0 r=ffffffff",
                  resp_valid, resp_id, resp_r);
      end
      @(negedge clk);
      tests_run++;
      if (resp_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL or_resp_drop: got v=%0b required 0", resp_valid);
      end
   endtask

   task automatic test_round_robin();
      logic        ids [3];
      logic [31:0] rs  [3];
      int          n;
      logic [31:0] exp_r [3];
      logic        exp_id [3];
      exp_r  = '{32'hFFFFFFFF, 32'hF000F000, 32'hFFFFFFFF};
      exp_id = '{1'b0, 1'b1, 1'b0};
      n = 0;
      do_reset();
      req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'hFFFFFFFF; req0_b = 32'h0;
      req1_valid = 1'b1; req1_op = 3'b000; req1_a = 32'hF0F0F0F0; req1_b = 32'hFF00FF00;
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++;
         $display("FAIL rr_first_tie: got %b required 10", {req0_ready, req1_ready});
      end
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) begin
            ids[n] = resp_id;
            rs[n]  = resp_r;
            n++;
         end
         if (n == 3) break;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tests_run++;
      if (n != 3) begin
         tests_failed++;
         $display("FAIL rr_count: got %0d responses required 3", n);
      end
      for (int i = 0; i < n; i++) begin
         tests_run++;
         if ({ids[i], rs[i]} !== {exp_id[i], exp_r[i]}) begin
            tests_failed++;
            $display("FAIL rr_grant%0d: got id=%0b r=%h required id=%0b r=%h",
                     i, ids[i], rs[i], exp_id[i], exp_r[i]);
         end
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      do_reset();
      resp_ready = 1'b0;
      req1_valid = 1'b1; req1_op = 3'b010; req1_a = 32'd5; req1_b = 32'd7;
      @(negedge clk);
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'h1; req0_b = 32'h2;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         tests_run++;
         if ({resp_valid, resp_r, req0_ready, req1_ready, resp_id} !==
             {1'b1, 32'd12, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL bp_hold%0d: got v=%0b r=%h rdy=%b id=%0b required v=1 r=0000000c rdy=00 id=1",
                     i, resp_valid, resp_r, {req0_ready, req1_ready}, resp_id);
         end
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      #1;
      tests_run++;
      if ({resp_valid, req0_ready} !== 2'b01) begin
         tests_failed++;
         $display("FAIL bp_resume: got v=%0b rdy0=%0b required v=0 rdy0=1", resp_valid, req0_ready);
      end
      req0_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int seen;
      seen = 0;
      do_reset();
      req0_valid = 1'b1; req0_op = 3'b011; req0_a = 32'h000000FF; req0_b = 32'h0000000F;
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({resp_valid, resp_id, resp_r, alu_op, alu_a, alu_b} !== '0) begin
         tests_failed++;
         $display("FAIL midrst_outputs: got v=%0b op=%0d a=%h b=%h r=%h required all 0",
                  resp_valid, alu_op, alu_a, alu_b, resp_r);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (resp_valid !== 1'b0) seen++;
      end
      tests_run++;
      if (seen != 0) begin
         tests_failed++;
         $display("FAIL midrst_no_resp: got %0d cycles with resp_valid required 0", seen);
      end
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++;
         $display("FAIL midrst_tie: got %b required 10", {req0_ready, req1_ready});
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_lone();
      int cyc [4];
      int n;
      int bad;
      n   = 0;
      bad = 0;
      do_reset();
      req1_valid = 1'b1; req1_op = 3'b110; req1_a = 32'd10; req1_b = 32'd3;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) begin
            cyc[n] = c;
            if ({resp_id, resp_r} !== {1'b1, 32'd7}) bad++;
            n++;
         end
         if (n == 4) break;
      end
      req1_valid = 1'b0;
      tests_run++;
      if (n != 4) begin
         tests_failed++;
         $display("FAIL lone_count: got %0d responses required 4", n);
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL lone_data: got %0d bad responses required 0 (id=1 r=7)", bad);
      end
      for (int i = 1; i < n; i++) begin
         tests_run++;
         if (cyc[i] - cyc[i-1] != 3) begin
            tests_failed++;
            $display("FAIL lone_spacing%0d: got %0d cycles required 3", i, cyc[i] - cyc[i-1]);
         end
      end
      @(negedge clk);
      @(negedge clk);
   endtask

`ifdef ALU_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      req0_op = 3'b000; req0_a = 32'h1; req0_b = 32'h1;
      for (int i = 0; i < 3; i++) begin
         req0_valid = 1'b1;
         @(negedge clk);
         req0_valid = 1'b0;
         @(negedge clk);
         @(negedge clk);
      end
      tests_run++;
      if ({gnt_cnt0, gnt_cnt1} !== {16'd3, 16'd0}) begin
         tests_failed++;
         $display("FAIL stats_cnt: got c0=%0d c1=%0d required c0=3 c1=0", gnt_cnt0, gnt_cnt1);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_or();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_lone();
`ifdef ALU_ARB_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
